jtag_chunk_assembler: RTL and testbench
=======================================

// Module: jtag_chunk_assembler
// PURPOSE
//  Reassembles a frame of NUM_CHUNKS words of CHUNK_W bits from the JTAG mailbox into one wide register.
//  Handshake: iPROGRESS rise = one chunk, iFINISH rise = end of frame.
//  Double-buffered: a completed frame is held on oFRAME for the consumer (e.g. SNN core) while the next frame fills.
//  Adds length checking, overrun/overflow flags and selectable chunk order to the ad-hoc top-level assembly.
// PARAMETERS
//  CHUNK_W      30   bits per JTAG chunk
//  NUM_CHUNKS   27   chunks per frame; FRAME_W = CHUNK_W*NUM_CHUNKS (810)
//  SYNC_STAGES  2    synchroniser flops on iPROGRESS/iFINISH (0 = already in iCLK domain)
//  MSB_FIRST    0    0: chunk k -> bits [k*CHUNK_W +: CHUNK_W]; 1: chunk k -> top-down slot NUM_CHUNKS-1-k
//  STRICT_LEN   1    1: short frame discarded with error; 0: published zero-padded
// PORTS
//  iCLK            in   1        main clock (120 MHz)
//  iRESET          in   1        asynchronous, active-high reset
//  iCHUNK          in   CHUNK_W  chunk data; stable from iPROGRESS rise until its fall
//  iPROGRESS       in   1        chunk strobe (level; rising edge counts)
//  iFINISH         in   1        end-of-frame strobe (level; rising edge counts)
//  iFRAME_ACK      in   1        consumer has taken oFRAME; clears oFRAME_RDY
//  iCLR_ERR        in   1        clears all sticky error flags
//  oFRAME          out  FRAME_W  last published frame
//  oFRAME_VALID    out  1        one-cycle pulse on publish
//  oFRAME_RDY      out  1        high from publish until iFRAME_ACK
//  oCHUNK_IDX      out  clog2(NUM_CHUNKS+1)  chunks received in current frame
//  oBUSY           out  1        frame in progress (state FILL or FULL)
//  oERR_SHORT      out  1        sticky: FINISH with 0<idx<NUM_CHUNKS
//  oERR_OVERFLOW   out  1        sticky: chunk received while FULL
//  oERR_OVERRUN    out  1        sticky: publish while oFRAME_RDY still high
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, idx 0, working buffer 0, sync/edge flops 0 (no edge on first high sample).
//  Strobes pass SYNC_STAGES flops, then a 1-flop edge detector; chunk written the cycle after the detected edge.
//  Latency iPROGRESS rise -> oCHUNK_IDX update = SYNC_STAGES+2 cycles.
//  Latency iFINISH rise -> oFRAME_VALID = SYNC_STAGES+2 cycles.
//  States: IDLE -chunk-> FILL (idx=1); FILL -chunk, idx==NUM_CHUNKS-> FULL; FILL/FULL -finish-> IDLE.
//  Chunk in IDLE/FILL: write working slot idx, idx++.
//  Chunk in FULL: dropped, oERR_OVERFLOW set, idx unchanged.
//  FINISH in IDLE (idx 0): ignored, no flags.
//  FINISH with idx==NUM_CHUNKS: copy working buffer -> oFRAME, pulse oFRAME_VALID, set oFRAME_RDY.
//  FINISH with 0<idx<NUM_CHUNKS: STRICT_LEN=1 -> discard, set oERR_SHORT, no publish; STRICT_LEN=0 -> publish, unwritten slots 0.
//  Every FINISH exit: working buffer cleared to 0, idx=0.
//  Chunk and FINISH edges in same cycle: chunk written first; FINISH judged on the incremented idx.
//  Publish while oFRAME_RDY=1: oFRAME overwritten, oERR_OVERRUN set, oFRAME_RDY stays 1.
//  iFRAME_ACK same cycle as publish: publish wins, oFRAME_RDY=1, no overrun.
//  iCLR_ERR same cycle as a new error: error wins (flag stays 1).
//  iRESET mid-frame: partial frame lost; oFRAME cleared; no flags asserted on release.
// STRUCTURE
//  Shared package jtag_if_pkg: state enum (IDLE, FILL, FULL), function clog2, slot-offset function (MSB_FIRST mapping).
//  Sub-module strobe_sync_edge (SYNC_STAGES flops + rise detect), instantiated twice.
//  Remainder is a single always block with the FSM, working buffer and output register.
// TESTING  (CHUNK_W=30, NUM_CHUNKS=27, SYNC_STAGES=2 unless noted)
//  27 chunks k=0..26 with data k+1, then FINISH.
//   -> oFRAME_VALID one cycle 4 cycles after FINISH rise; oFRAME[30*k+:30]==k+1; oFRAME_RDY=1; no errors.
//  Same stream with MSB_FIRST=1 -> chunk 0 (value 1) at oFRAME[809:780].
//  5 chunks then FINISH, STRICT_LEN=1 -> no publish, oERR_SHORT=1, idx=0.
//  5 chunks then FINISH, STRICT_LEN=0 -> publish with bits [809:150]==0.
//  28 chunks then FINISH -> oERR_OVERFLOW=1, frame published with 28th chunk absent.
//  Two full frames, no iFRAME_ACK -> oERR_OVERRUN=1, oFRAME holds 2nd frame.
//  Then iCLR_ERR -> all flags 0.
//  iRESET after 10 chunks, then full frame -> clean publish of new frame; iPROGRESS held high across reset gives no spurious chunk.

Source files
------------

// File: rtl/jtag_if_pkg.sv
`default_nettype none
// ============================================================================
// Module : jtag_if_pkg
// Brief  : Shared types and helpers for the JTAG mailbox chunk assembler.
// Rev    : 1.0  initial release
// ============================================================================
package jtag_if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Bit offset of chunk k inside the frame; MSB-first fills from the top slot down.
    function automatic int slot_offset(input int k, input int chunk_w,
                                       input int num_chunks, input bit msb_first);
        return msb_first ? (num_chunks - 1 - k) * chunk_w : k * chunk_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/strobe_sync_edge.sv
`default_nettype none
// ============================================================================
// Module : strobe_sync_edge
// Brief  : Level strobe synchroniser followed by a registered rising-edge pulse.
// Rev    : 1.0  initial release
// ============================================================================
module strobe_sync_edge
    import jtag_if_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    output logic rise
);

    localparam int WARM   = SYNC_STAGES + 1;
    localparam int WARM_W = clog2(WARM + 1);

    logic              w_synced;
    logic              r_prev;
    logic [WARM_W-1:0] r_warm;
    logic              w_armed;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [SYNC_STAGES-1:0] r_chain;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_chain <= '0;
                end else begin
                    r_chain[0] <= strobe;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_chain[i] <= r_chain[i-1];
                    end
                end
            end
            assign w_synced = r_chain[SYNC_STAGES-1];
        end else begin : g_nosync
            assign w_synced = strobe;
        end
    endgenerate

    // Edges are only trusted once r_prev holds a real sample, so a strobe
    // held high through reset never looks like a fresh rise.
    assign w_armed = (r_warm == WARM_W'(WARM));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 1'b0;
            r_warm <= '0;
            rise   <= 1'b0;
        end else begin
            r_prev <= w_synced;
            if (!w_armed) begin
                r_warm <= r_warm + WARM_W'(1);
            end
            rise <= w_armed & w_synced & ~r_prev;
        end
    end

endmodule
`default_nettype wire

// File: rtl/jtag_chunk_assembler.sv
`default_nettype none
// ============================================================================
// Module : jtag_chunk_assembler
// Brief  : Collects JTAG mailbox chunks into a double-buffered wide frame.
// Rev    : 1.0  initial release
// ============================================================================
module jtag_chunk_assembler
    import jtag_if_pkg::*;
#(
    parameter int CHUNK_W     = 30,
    parameter int NUM_CHUNKS  = 27,
    parameter int SYNC_STAGES = 2,
    parameter int MSB_FIRST   = 0,
    parameter int STRICT_LEN  = 1
) (
    input  logic                                 iCLK,
    input  logic                                 iRESET,
    input  logic [CHUNK_W-1:0]                   iCHUNK,
    input  logic                                 iPROGRESS,
    input  logic                                 iFINISH,
    input  logic                                 iFRAME_ACK,
    input  logic                                 iCLR_ERR,
    output logic [CHUNK_W*NUM_CHUNKS-1:0]        oFRAME,
    output logic                                 oFRAME_VALID,
    output logic                                 oFRAME_RDY,
    output logic [clog2(NUM_CHUNKS+1)-1:0]       oCHUNK_IDX,
    output logic                                 oBUSY,
    output logic                                 oERR_SHORT,
    output logic                                 oERR_OVERFLOW,
    output logic                                 oERR_OVERRUN
);

    localparam int FRAME_W = CHUNK_W * NUM_CHUNKS;
    localparam int IDX_W   = clog2(NUM_CHUNKS + 1);

    logic               w_chunk_rise;
    logic               w_finish_rise;
    state_t             r_state, w_state_nx;
    logic [FRAME_W-1:0] r_work, w_work_nx, w_frame_nx;
    logic [IDX_W-1:0]   w_idx_nx;
    int                 w_slot_off;
    logic               w_publish, w_short, w_overflow;

    strobe_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_progress_edge (
        .clk    (iCLK),
        .rst    (iRESET),
        .strobe (iPROGRESS),
        .rise   (w_chunk_rise)
    );

    strobe_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_finish_edge (
        .clk    (iCLK),
        .rst    (iRESET),
        .strobe (iFINISH),
        .rise   (w_finish_rise)
    );

    assign oBUSY = (r_state != IDLE);

    // A chunk landing in the same cycle as FINISH is applied first, and the
    // frame length is judged on the incremented index.
    always_comb begin
        w_state_nx = r_state;
        w_work_nx  = r_work;
        w_idx_nx   = oCHUNK_IDX;
        w_frame_nx = '0;
        w_publish  = 1'b0;
        w_short    = 1'b0;
        w_overflow = 1'b0;
        w_slot_off = slot_offset(int'(oCHUNK_IDX), CHUNK_W, NUM_CHUNKS, MSB_FIRST != 0);

        if (w_chunk_rise) begin
            if (r_state == FULL) begin
                w_overflow = 1'b1;
            end else begin
                w_work_nx[w_slot_off +: CHUNK_W] = iCHUNK;
                w_idx_nx   = oCHUNK_IDX + IDX_W'(1);
                w_state_nx = (w_idx_nx == IDX_W'(NUM_CHUNKS)) ? FULL : FILL;
            end
        end

        if (w_finish_rise && (w_idx_nx != '0)) begin
            if ((w_idx_nx == IDX_W'(NUM_CHUNKS)) || (STRICT_LEN == 0)) begin
                w_publish = 1'b1;
            end else begin
                w_short = 1'b1;
            end
            w_frame_nx = w_work_nx;
            w_work_nx  = '0;
            w_idx_nx   = '0;
            w_state_nx = IDLE;
        end
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            r_state       <= IDLE;
            r_work        <= '0;
            oCHUNK_IDX    <= '0;
            oFRAME        <= '0;
            oFRAME_VALID  <= 1'b0;
            oFRAME_RDY    <= 1'b0;
            oERR_SHORT    <= 1'b0;
            oERR_OVERFLOW <= 1'b0;
            oERR_OVERRUN  <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_work       <= w_work_nx;
            oCHUNK_IDX   <= w_idx_nx;
            oFRAME_VALID <= w_publish;
            if (w_publish) begin
                oFRAME     <= w_frame_nx;
                oFRAME_RDY <= 1'b1;
            end else if (iFRAME_ACK) begin
                oFRAME_RDY <= 1'b0;
            end
            oERR_SHORT    <= (oERR_SHORT    & ~iCLR_ERR) | w_short;
            oERR_OVERFLOW <= (oERR_OVERFLOW & ~iCLR_ERR) | w_overflow;
            oERR_OVERRUN  <= (oERR_OVERRUN  & ~iCLR_ERR) |
                             (w_publish & oFRAME_RDY & ~iFRAME_ACK);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtag_chunk_assembler.sv
`default_nettype none
// ============================================================================
// Module : tb_jtag_chunk_assembler
// Brief  : Self-checking bench; three configurations share one stimulus stream.
// Rev    : 1.0  initial release
// ============================================================================
module tb_jtag_chunk_assembler;

    localparam int CW = 30;
    localparam int NC = 27;
    localparam int FW = CW * NC;
    localparam int ND = 3;  // 0: LSB/strict, 1: MSB/strict, 2: LSB/lenient

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] chunk;
    logic          progress, finish, ack, clr_err;

    logic [FW-1:0] frame    [ND];
    logic          valid    [ND];
    logic          rdy      [ND];
    logic [4:0]    idx      [ND];
    logic          busy     [ND];
    logic          err_short[ND];
    logic          err_ovf  [ND];
    logic          err_ovr  [ND];

    always #5 clk = ~clk;

    jtag_chunk_assembler #(.MSB_FIRST(0), .STRICT_LEN(1)) dut_lsb (
        .iCLK(clk), .iRESET(rst), .iCHUNK(chunk), .iPROGRESS(progress), .iFINISH(finish),
        .iFRAME_ACK(ack), .iCLR_ERR(clr_err), .oFRAME(frame[0]), .oFRAME_VALID(valid[0]),
        .oFRAME_RDY(rdy[0]), .oCHUNK_IDX(idx[0]), .oBUSY(busy[0]), .oERR_SHORT(err_short[0]),
        .oERR_OVERFLOW(err_ovf[0]), .oERR_OVERRUN(err_ovr[0]));

    jtag_chunk_assembler #(.MSB_FIRST(1), .STRICT_LEN(1)) dut_msb (
        .iCLK(clk), .iRESET(rst), .iCHUNK(chunk), .iPROGRESS(progress), .iFINISH(finish),
        .iFRAME_ACK(ack), .iCLR_ERR(clr_err), .oFRAME(frame[1]), .oFRAME_VALID(valid[1]),
        .oFRAME_RDY(rdy[1]), .oCHUNK_IDX(idx[1]), .oBUSY(busy[1]), .oERR_SHORT(err_short[1]),
        .oERR_OVERFLOW(err_ovf[1]), .oERR_OVERRUN(err_ovr[1]));

    jtag_chunk_assembler #(.MSB_FIRST(0), .STRICT_LEN(0)) dut_len (
        .iCLK(clk), .iRESET(rst), .iCHUNK(chunk), .iPROGRESS(progress), .iFINISH(finish),
        .iFRAME_ACK(ack), .iCLR_ERR(clr_err), .oFRAME(frame[2]), .oFRAME_VALID(valid[2]),
        .oFRAME_RDY(rdy[2]), .oCHUNK_IDX(idx[2]), .oBUSY(busy[2]), .oERR_SHORT(err_short[2]),
        .oERR_OVERFLOW(err_ovf[2]), .oERR_OVERRUN(err_ovr[2]));

    // Reference model: the list of chunks accepted in the current frame plus
    // per-configuration expected outputs.
    bit            cfg_msb   [ND] = '{1'b0, 1'b1, 1'b0};
    bit            cfg_strict[ND] = '{1'b1, 1'b1, 1'b0};
    logic [CW-1:0] m_data [NC];
    int            m_cnt;
    logic [FW-1:0] e_frame[ND];
    bit            e_rdy[ND], e_short[ND], e_ovf[ND], e_ovr[ND];
    int            e_pulses[ND];
    int            n_pulses[ND];

    int vecs = 0;
    int miss = 0;

    always @(posedge clk) begin
        for (int c = 0; c < ND; c++) begin
            if (valid[c] === 1'b1) n_pulses[c]++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [269:0] obs, input logic [269:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] build(input bit msb);
        logic [FW-1:0] f = '0;
        for (int k = 0; k < m_cnt; k++) begin
            f[(msb ? (NC - 1 - k) : k) * CW +: CW] = m_data[k];
        end
        return f;
    endfunction

    task automatic model_chunk(input logic [CW-1:0] d);
        if (m_cnt == NC) begin
            for (int c = 0; c < ND; c++) e_ovf[c] = 1'b1;
        end else begin
            m_data[m_cnt] = d;
            m_cnt++;
        end
    endtask

    task automatic model_finish();
        if (m_cnt != 0) begin
            for (int c = 0; c < ND; c++) begin
                if (m_cnt == NC || !cfg_strict[c]) begin
                    if (e_rdy[c]) e_ovr[c] = 1'b1;
                    e_frame[c] = build(cfg_msb[c]);
                    e_rdy[c]   = 1'b1;
                    e_pulses[c]++;
                end else begin
                    e_short[c] = 1'b1;
                end
            end
        end
        m_cnt = 0;
    endtask

    task automatic model_reset();
        m_cnt = 0;
        for (int c = 0; c < ND; c++) begin
            e_frame[c] = '0;
            e_rdy[c] = 1'b0; e_short[c] = 1'b0; e_ovf[c] = 1'b0; e_ovr[c] = 1'b0;
        end
    endtask

    task automatic send_chunk(input logic [CW-1:0] d);
        chunk = d; progress = 1'b1;
        tick(5);
        progress = 1'b0;
        tick(4);
        model_chunk(d);
    endtask

    task automatic send_finish();
        finish = 1'b1;
        tick(5);
        finish = 1'b0;
        tick(4);
        model_finish();
    endtask

    task automatic send_random(input int n);
        for (int i = 0; i < n; i++) send_chunk(CW'($urandom));
    endtask

    task automatic pulse_ack();
        ack = 1'b1; tick(1); ack = 1'b0; tick(2);
        for (int c = 0; c < ND; c++) e_rdy[c] = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1; tick(1); clr_err = 1'b0; tick(2);
        for (int c = 0; c < ND; c++) begin
            e_short[c] = 1'b0; e_ovf[c] = 1'b0; e_ovr[c] = 1'b0;
        end
    endtask

    task automatic check_all(input string step);
        for (int c = 0; c < ND; c++) begin
            for (int p = 0; p < 3; p++) begin
                chk($sformatf("%s.frame%0d[%0d]", step, c, p),
                    frame[c][p*270 +: 270], e_frame[c][p*270 +: 270]);
            end
            chk($sformatf("%s.rdy%0d", step, c),      270'(rdy[c]),       270'(e_rdy[c]));
            chk($sformatf("%s.short%0d", step, c),    270'(err_short[c]), 270'(e_short[c]));
            chk($sformatf("%s.ovf%0d", step, c),      270'(err_ovf[c]),   270'(e_ovf[c]));
            chk($sformatf("%s.ovr%0d", step, c),      270'(err_ovr[c]),   270'(e_ovr[c]));
            chk($sformatf("%s.idx%0d", step, c),      270'(idx[c]),       270'(m_cnt));
            chk($sformatf("%s.pulses%0d", step, c),   270'(n_pulses[c]),  270'(e_pulses[c]));
        end
    endtask

    initial begin
        rst = 1'b1; chunk = '0; progress = 1'b0; finish = 1'b0; ack = 1'b0; clr_err = 1'b0;
        for (int c = 0; c < ND; c++) begin e_pulses[c] = 0; n_pulses[c] = 0; end
        model_reset();
        tick(3);
        check_all("reset");
        chk("reset.busy", 270'(busy[0]), 270'(0));
        chk("reset.valid", 270'(valid[0]), 270'(0));
        rst = 1'b0;
        tick(6);

        // Frame of k+1 values, with strobe-to-output latency probed on the first chunk.
        chunk = CW'(1); progress = 1'b1;
        tick(3);
        chk("lat.idx_early", 270'(idx[0]), 270'(0));
        tick(1);
        chk("lat.idx_on", 270'(idx[0]), 270'(1));
        chk("lat.busy", 270'(busy[0]), 270'(1));
        tick(1); progress = 1'b0; tick(4);
        model_chunk(CW'(1));
        for (int k = 1; k < NC; k++) send_chunk(CW'(k + 1));
        chk("full.idx", 270'(idx[0]), 270'(NC));
        finish = 1'b1;
        tick(3);
        chk("lat.valid_early", 270'(valid[0]), 270'(0));
        tick(1);
        chk("lat.valid_on", 270'(valid[0]), 270'(1));
        tick(1);
        chk("lat.valid_off", 270'(valid[0]), 270'(0));
        finish = 1'b0; tick(4);
        model_finish();
        check_all("seq");
        chk("seq.lsb_chunk0", 270'(frame[0][29:0]), 270'(1));
        chk("seq.msb_chunk0", 270'(frame[1][809:780]), 270'(1));
        chk("seq.lsb_chunk26", 270'(frame[0][809:780]), 270'(27));
        pulse_ack();

        send_finish();
        check_all("idle_finish");

        send_random(5);
        send_finish();
        check_all("short");
        chk("short.pad", 270'(frame[2][809:540]), 270'(0));
        pulse_ack();
        pulse_clr();

        send_random(NC);
        chk("overflow.busy", 270'(busy[0]), 270'(1));
        send_random(1);
        send_finish();
        check_all("overflow");
        pulse_ack();
        pulse_clr();

        send_random(NC); send_finish();
        send_random(NC); send_finish();
        check_all("overrun");
        pulse_clr();
        check_all("clr");
        pulse_ack();

        // Reset mid-frame with PROGRESS held high across the release.
        send_random(10);
        chunk = CW'($urandom); progress = 1'b1; rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(8);
        model_reset();
        check_all("midreset");
        progress = 1'b0; tick(4);
        send_random(NC); send_finish();
        check_all("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

    initial begin
        #2000000;
        miss++;
        $display("FAIL timeout vecs=%0d", vecs);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
